if_id_skid_reg: RTL and testbench
=================================

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, width of the PC and instruction fields.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1, fetch stage presents a PC/instruction pair.
REQ-005 The block SHALL have port in_ready, output, 1, block accepts the pair this cycle.
REQ-006 The block SHALL have ports in_pc and in_inst, input, XLEN each, incoming PC and instruction.
REQ-007 The block SHALL have port out_valid, output, 1, decode-side pair is valid.
REQ-008 The block SHALL have port out_ready, input, 1, decode stage consumes the pair this cycle.
REQ-009 The block SHALL have ports out_pc and out_inst, output, XLEN each, registered PC and instruction.
REQ-010 The block SHALL have port flush, input, 1, discard all held entries; present only when IFID_FLUSH_EN is defined.

Function
REQ-011 Input handshake SHALL occur when in_valid && in_ready; output handshake SHALL occur when out_valid && out_ready.
REQ-012 Storage SHALL be a main register (drives out_*) and one skid register, each holding {pc, inst}.
REQ-013 The state machine SHALL have three states: EMPTY (no entries), BUSY (main only), FULL (main and skid).
REQ-014 in_ready SHALL equal (state != FULL), and out_valid SHALL equal (state != EMPTY); both are decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-015 EMPTY with input handshake: main <= in, go to BUSY; otherwise remain in EMPTY.
REQ-016 BUSY with input and output handshake: main <= in, remain in BUSY (full throughput, one pair per cycle).
REQ-017 BUSY with input handshake and no output handshake: skid <= in, go to FULL; main is unchanged.
REQ-018 BUSY with output handshake and no input handshake: go to EMPTY.
REQ-019 BUSY with neither handshake: hold main and state.
REQ-020 FULL with out_ready: main <= skid, go to BUSY; in_valid is ignored because in_ready = 0.
REQ-021 FULL without out_ready: hold both registers and state.
REQ-022 Latency from input handshake to out_valid SHALL be 1 cycle when the block is EMPTY or passing through in BUSY.
REQ-023 Pair ordering SHALL be strictly preserved, with no loss or duplication.
REQ-024 out_pc and out_inst SHALL be stable while out_valid && !out_ready.
REQ-025 When state is EMPTY, out_pc and out_inst SHALL hold their last values; their content is don't-care to decode.

Reset
REQ-026 Assertion of rst (low) SHALL immediately set state to EMPTY and main and skid to 0, so out_valid = 0, out_pc = out_inst = 0, and in_ready = 1.
REQ-027 Reset asserted mid-transfer SHALL drop every held entry, with no partial update.
REQ-028 The first input handshake SHALL be possible on the first rising clk edge after rst deasserts.

Configuration
REQ-029 Macro IFID_FLUSH_EN SHALL control the flush port.
REQ-030 With IFID_FLUSH_EN defined: flush sampled high at a rising edge SHALL set state to EMPTY at that edge, overriding every transition in REQ-015 to REQ-021.
REQ-031 With IFID_FLUSH_EN defined: an input handshake in the flush cycle SHALL count as accepted and be discarded.
REQ-032 With IFID_FLUSH_EN defined: main and skid data SHALL keep their values on flush, since only state is cleared.
REQ-033 With IFID_FLUSH_EN undefined: the flush port SHALL be absent, and behaviour SHALL be identical to flush tied to 0.

Verification
REQ-034 Reset: drive rst low mid-FULL with pc 0x100 and 0x104 held -> immediately out_valid = 0, in_ready = 1, out_pc = 0; neither entry appears after release.
REQ-035 Streaming: out_ready = 1, pairs pc 0x0, 0x4, 0x8 on consecutive cycles -> out_pc 0x0, 0x4, 0x8 each one cycle later, in_ready constantly 1.
REQ-036 Backpressure: out_ready = 0, send pc 0x10 then 0x14 -> after the second handshake in_ready = 0 and out_pc = 0x10 held; raise out_ready -> 0x10 then 0x14 delivered in order, in_ready = 1 again.
REQ-037 FULL ignore: in FULL, drive in_valid with pc 0x18 while out_ready = 0 -> 0x18 never appears on out_pc.
REQ-038 Drain: BUSY with pc 0x20, in_valid = 0, out_ready = 1 -> next cycle out_valid = 0.
REQ-039 Flush (IFID_FLUSH_EN defined): in FULL, flush = 1 with in_valid = 0 -> next cycle out_valid = 0, in_ready = 1; then pc 0x40 sent -> out_pc = 0x40 after 1 cycle.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with one-entry skid buffer; ready/valid on both sides, fully registered outputs.
// Optional synchronous flush port enabled by defining IFID_FLUSH_EN.
module if_id_skid_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
`ifdef IFID_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);

  // state | meaning
  // EMPTY | no entries held
  // BUSY  | main register holds the only entry
  // FULL  | main holds the oldest entry, skid holds the next one
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [XLEN-1:0] main_inst_q, main_inst_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_inst_q, skid_inst_d;
  logic            flush_w;
  logic            in_hs;
  logic            out_hs;

`ifdef IFID_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_pc    = main_pc_q;
  assign out_inst  = main_inst_q;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    unique case (state_q)
      EMPTY: begin
        if (in_hs) begin
          main_pc_d   = in_pc;
          main_inst_d = in_inst;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (in_hs && out_hs) begin
          main_pc_d   = in_pc;
          main_inst_d = in_inst;
        end else if (in_hs) begin
          skid_pc_d   = in_pc;
          skid_inst_d = in_inst;
          state_d     = FULL;
        end else if (out_hs) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          main_pc_d   = skid_pc_q;
          main_inst_d = skid_inst_q;
          state_d     = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush clears occupancy only; data registers keep their contents.
    if (flush_w) begin
      state_d     = EMPTY;
      main_pc_d   = main_pc_q;
      main_inst_d = main_inst_q;
      skid_pc_d   = skid_pc_q;
      skid_inst_d = skid_inst_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_pc_q   <= '0;
      main_inst_q <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Randomized + directed bench for if_id_skid_reg against a two-deep FIFO reference model.
module tb_if_id_skid_reg;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  int n_checks = 0;
  int n_errors = 0;

  logic [XLEN-1:0] mq_pc[$];
  logic [XLEN-1:0] mq_inst[$];
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] last_inst;

  always #5 clk = ~clk;

  if_id_skid_reg #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef IFID_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_inst (out_inst)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_inst.delete();
    last_pc   = '0;
    last_inst = '0;
  endtask

  task automatic check_model();
    chk("out_valid", {31'b0, out_valid}, (mq_pc.size() > 0) ? 32'd1 : 32'd0);
    chk("in_ready", {31'b0, in_ready}, (mq_pc.size() < 2) ? 32'd1 : 32'd0);
    chk("out_pc", out_pc, last_pc);
    chk("out_inst", out_inst, last_inst);
  endtask

  task automatic drive(input bit iv, input logic [XLEN-1:0] pc, input bit ordy, input bit fl);
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = $urandom;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock: update the FIFO model at the edge, compare on the falling edge.
  task automatic cycle();
    bit ih, oh;
    @(posedge clk);
    ih = in_valid && (mq_pc.size() < 2);
    oh = out_ready && (mq_pc.size() > 0);
    if (flush) begin
      mq_pc.delete();
      mq_inst.delete();
    end else begin
      if (oh) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (ih) begin
        mq_pc.push_back(in_pc);
        mq_inst.push_back(in_inst);
      end
    end
    if (mq_pc.size() > 0) begin
      last_pc   = mq_pc[0];
      last_inst = mq_inst[0];
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst = 1'b0;
    drive(0, '0, 0, 0);
    model_reset();
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_out_inst", out_inst, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Streaming at full throughput, first accept on first edge after reset release
    drive(1, 32'h0, 1, 0); cycle();
    chk("stream_pc0", out_pc, 32'h0);
    drive(1, 32'h4, 1, 0); cycle();
    chk("stream_pc4", out_pc, 32'h4);
    chk("stream_rdy", {31'b0, in_ready}, 32'd1);
    drive(1, 32'h8, 1, 0); cycle();
    chk("stream_pc8", out_pc, 32'h8);
    drive(0, '0, 1, 0); cycle();

    // Backpressure, then ignored input while FULL
    drive(1, 32'h10, 0, 0); cycle();
    drive(1, 32'h14, 0, 0); cycle();
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_pc", out_pc, 32'h10);
    drive(1, 32'h18, 0, 0); cycle();
    chk("full_ignore_pc", out_pc, 32'h10);
    drive(0, '0, 1, 0); cycle();
    chk("bp_second_pc", out_pc, 32'h14);
    chk("bp_ready_again", {31'b0, in_ready}, 32'd1);
    cycle();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // Drain from BUSY
    drive(1, 32'h20, 0, 0); cycle();
    chk("drain_pc", out_pc, 32'h20);
    drive(0, '0, 1, 0); cycle();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset while FULL
    drive(1, 32'h100, 0, 0); cycle();
    drive(1, 32'h104, 0, 0); cycle();
    chk("prereset_full", {31'b0, in_ready}, 32'd0);
    drive(0, '0, 0, 0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midreset_out_pc", out_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, '0, 1, 0);
    repeat (3) cycle();
    chk("postreset_pc", out_pc, 32'h0);

`ifdef IFID_FLUSH_EN
    drive(1, 32'h30, 0, 0); cycle();
    drive(1, 32'h34, 0, 0); cycle();
    drive(0, '0, 0, 1); cycle();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    drive(1, 32'h40, 0, 0); cycle();
    chk("flush_next_pc", out_pc, 32'h40);
    drive(1, 32'h44, 1, 1); cycle();
    chk("flush_discard", {31'b0, out_valid}, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit fl;
      fl = 1'b0;
`ifdef IFID_FLUSH_EN
      fl = ($urandom_range(0, 19) == 0);
`endif
      drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0, fl);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
